// File: rtl/serial_adder_subtractor.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice, LSB first, start/done handshake.
// Define SERIAL_ADDSUB_SAT_EN to unsigned-saturate the result; undefined, the result wraps.
module serial_adder_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] final_result;
  logic [5:0]       idx;
  logic             sub_q;
  logic             carry;
  logic             b_eff;
  logic             sum_bit;
  logic             carry_next;
  logic             last;

  assign last = (idx == 6'(WIDTH - 1));

  // Single full-adder slice; the partial sum enters the shift register at the MSB.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    b_eff        = op_b[0] ^ sub_q;
    sum_bit      = op_a[0] ^ b_eff ^ carry;
    carry_next   = (op_a[0] & b_eff) | (op_a[0] & carry) | (b_eff & carry);
    acc_next     = acc >> 1;
    acc_next[WIDTH-1] = sum_bit;
    final_result = acc_next;
`ifdef SERIAL_ADDSUB_SAT_EN
    if (!sub_q && carry_next)
      final_result = '1;
    else if (sub_q && !carry_next)
      final_result = '0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      idx       <= '0;
      sub_q     <= 1'b0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            sub_q <= sub;
            carry <= sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= carry_next;
          acc   <= acc_next;
          idx   <= idx + 6'd1;
          if (last) begin
            // carry still holds the carry into the MSB here
            result    <= final_result;
            carry_out <= carry_next;
            overflow  <= carry ^ carry_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Self-checking bench for serial_adder_subtractor (WIDTH=8); honours SERIAL_ADDSUB_SAT_EN if defined.
module tb_serial_adder_subtractor;

  localparam int WP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          sub = 1'b0;
  logic [WP-1:0] a = '0;
  logic [WP-1:0] b = '0;
  logic          busy;
  logic          done;
  logic [WP-1:0] result;
  logic          carry_out;
  logic          overflow;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  serial_adder_subtractor #(.WIDTH(WP)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain integer add/subtract, then derive flags from ranges.
  function automatic void model(input logic [WP-1:0] x, input logic [WP-1:0] y, input logic s,
                                output logic [WP-1:0] r, output logic c, output logic v);
    longint ux, uy, sx, sy, us, ss;
    ux = longint'(x);
    uy = longint'(y);
    sx = x[WP-1] ? ux - (longint'(1) << WP) : ux;
    sy = y[WP-1] ? uy - (longint'(1) << WP) : uy;
    if (s) begin
      us = ux - uy;
      ss = sx - sy;
      c  = (ux >= uy);
    end else begin
      us = ux + uy;
      ss = sx + sy;
      c  = (us >= (longint'(1) << WP));
    end
    v = (ss > (longint'(1) << (WP - 1)) - 1) || (ss < -(longint'(1) << (WP - 1)));
    r = us[WP-1:0];
`ifdef SERIAL_ADDSUB_SAT_EN
    if (!s && c) r = '1;
    if (s && !c) r = '0;
`endif
  endfunction

  // Transaction-level timing model: 0 idle, 1..WP computing, WP+1 done cycle.
  int            phase = 0;
  logic [WP-1:0] pa = '0, pb = '0;
  logic          ps = 1'b0;
  logic [WP-1:0] m_result = '0;
  logic          m_c = 1'b0, m_v = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    = 0;
      m_result = '0;
      m_c      = 1'b0;
      m_v      = 1'b0;
    end else if ((phase == 0 || phase == WP + 1) && start) begin
      pa    = a;
      pb    = b;
      ps    = sub;
      phase = 1;
    end else if (phase >= 1 && phase <= WP) begin
      phase++;
      if (phase == WP + 1) model(pa, pb, ps, m_result, m_c, m_v);
    end else begin
      phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 32'(busy), 32'(phase >= 1 && phase <= WP));
      check("cyc_done", 32'(done), 32'(phase == WP + 1));
      check("cyc_result", 32'(result), 32'(m_result));
      check("cyc_carry", 32'(carry_out), 32'(m_c));
      check("cyc_ovf", 32'(overflow), 32'(m_v));
    end
  end

  // One operation from idle; optionally pulse start 'poke' cycles after acceptance.
  task automatic run_op(input string tag, input logic [WP-1:0] x, input logic [WP-1:0] y,
                        input logic s, input logic [WP-1:0] er, input logic ec, input logic ev,
                        input int poke);
    int n = 0;
    int bc = 0;
    bit seen = 1'b0;
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = WP'($urandom); b = WP'($urandom); sub = 1'($urandom);
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
      if (done) seen = 1'b1;
      if (poke != 0 && n == poke) begin
        start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, "_latency"}, 32'(n), 32'(WP + 1));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(WP));
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_carry"}, 32'(carry_out), 32'(ec));
    check({tag, "_ovf"}, 32'(overflow), 32'(ev));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
  endtask

  initial begin
    int n;
    int dones;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    run_op("add_100_27", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, 0);
`ifdef SERIAL_ADDSUB_SAT_EN
    run_op("add_200_100", 8'd200, 8'd100, 1'b0, 8'd255, 1'b1, 1'b0, 0);
    run_op("sub_5_9", 8'd5, 8'd9, 1'b1, 8'h00, 1'b0, 1'b0, 0);
`else
    run_op("add_200_100", 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0, 0);
    run_op("sub_5_9", 8'd5, 8'd9, 1'b1, 8'hFC, 1'b0, 1'b0, 0);
`endif
    run_op("add_ovf", 8'd100, 8'd100, 1'b0, 8'd200, 1'b0, 1'b1, 0);
    run_op("sub_ovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
    run_op("ignored_start", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, 3);
    repeat (2) @(negedge clk);

    // start held through the done cycle: second operation accepted there
    a = 8'd10; b = 8'd20; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'd30; b = 8'd40; sub = 1'b1;
    wait_done(n);
    check("b2b_first_latency", 32'(n), 32'(WP + 1));
    check("b2b_first_result", 32'(result), 32'd30);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check("b2b_second_latency", 32'(n), 32'(WP + 1));
`ifdef SERIAL_ADDSUB_SAT_EN
    check("b2b_second_result", 32'(result), 32'h00);
`else
    check("b2b_second_result", 32'(result), 32'hF6);
`endif
    check("b2b_second_carry", 32'(carry_out), 32'd0);

    // asynchronous abort four cycles into the computation
    @(negedge clk);
    a = 8'd100; b = 8'd27; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_carry", 32'(carry_out), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_op("after_abort", 8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
